// File: rtl/led_blinker_pkg.sv
// -----------------------------------------------------------------------------
// led_blinker_pkg
// Shared types and helpers for the multi-channel LED blinker.
//   led_mode_t  : per-channel operating mode (OFF / ON / BLINK / BURST)
//   BURST_W     : width of the burst pulse count and pulse counter
//   clog2_min1  : ceil(log2(n)), but never less than 1 bit
// Optional feature macro used by the design: LED_BLINKER_BURST_EN
// -----------------------------------------------------------------------------
package led_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } led_mode_t;

  localparam int BURST_W = 8;

  // Index widths must stay at least one bit wide even for a single channel
  // or a divide-by-one prescaler.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_blink_channel.sv
// -----------------------------------------------------------------------------
// led_blink_channel
// One LED channel: config registers, tick-driven period counter, burst pulse
// counter and the registered LED / burst-done outputs.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   tick           : shared prescaler pulse, advances the period counter
//   wr_en          : load wr_* into the config registers this cycle
//   wr_mode        : new mode
//   wr_period      : new period in ticks (0 is treated as 1)
//   wr_high        : new high time in ticks
//   wr_burst       : new burst pulse count
//   led            : registered LED drive
//   burst_done     : sticky burst-complete flag
// Macro LED_BLINKER_BURST_EN enables BURST mode; without it mode 3 runs as
// BLINK, wr_burst is ignored and burst_done is tied low.
// -----------------------------------------------------------------------------
module led_blink_channel
  import led_blinker_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               wr_en,
  input  led_mode_t          wr_mode,
  input  logic [CNT_W-1:0]   wr_period,
  input  logic [CNT_W-1:0]   wr_high,
  input  logic [BURST_W-1:0] wr_burst,
  output logic               led,
  output logic               burst_done
);

  led_mode_t        mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;

  logic [CNT_W-1:0] eff_period;
  logic             at_end;
  logic             burst_reached;

`ifdef LED_BLINKER_BURST_EN
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;
  logic               done_q, done_d;
`else
  logic               unused_burst;
  assign unused_burst = ^wr_burst;
`endif

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    high_d   = high_q;
    cnt_d    = cnt_q;
    led_d    = 1'b0;

    eff_period = (period_q == '0) ? CNT_W'(1) : period_q;
    at_end     = (cnt_q >= (eff_period - CNT_W'(1)));

`ifdef LED_BLINKER_BURST_EN
    burst_d       = burst_q;
    pcnt_d        = pcnt_q;
    burst_reached = (mode_q == MODE_BURST) && (pcnt_q == burst_q);
`else
    burst_reached = 1'b0;
`endif

    case (mode_q)
      MODE_OFF: begin
        led_d = 1'b0;
        cnt_d = '0;
      end
      MODE_ON: begin
        led_d = 1'b1;
        cnt_d = '0;
      end
      default: begin
        // BLINK, and BURST while pulses remain. A finished burst idles with
        // the counter frozen so the pulse count cannot move past the target.
        if (burst_reached) begin
          led_d = 1'b0;
        end else begin
          led_d = (cnt_q < high_q);
          if (tick) begin
            if (at_end) begin
              cnt_d = '0;
`ifdef LED_BLINKER_BURST_EN
              if (mode_q == MODE_BURST) begin
                pcnt_d = pcnt_q + BURST_W'(1);
              end
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
    endcase

`ifdef LED_BLINKER_BURST_EN
    done_d = done_q | burst_reached;
`endif

    // A write overrides any tick in the same cycle; the LED flop keeps
    // computing from the old state, so the new config shows one cycle later.
    if (wr_en) begin
      mode_d   = wr_mode;
      period_d = wr_period;
      high_d   = wr_high;
      cnt_d    = '0;
`ifdef LED_BLINKER_BURST_EN
      burst_d  = wr_burst;
      pcnt_d   = '0;
      done_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_OFF;
      period_q <= '0;
      high_q   <= '0;
      cnt_q    <= '0;
      led_q    <= 1'b0;
`ifdef LED_BLINKER_BURST_EN
      burst_q  <= '0;
      pcnt_q   <= '0;
      done_q   <= 1'b0;
`endif
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      high_q   <= high_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
`ifdef LED_BLINKER_BURST_EN
      burst_q  <= burst_d;
      pcnt_q   <= pcnt_d;
      done_q   <= done_d;
`endif
    end
  end

  assign led = led_q;
`ifdef LED_BLINKER_BURST_EN
  assign burst_done = done_q;
`else
  assign burst_done = 1'b0;
`endif

endmodule

// File: rtl/led_blinker_multi.sv
// -----------------------------------------------------------------------------
// led_blinker_multi
// Multi-channel LED driver. Holds the shared prescaler, the config
// valid/ready handshake and the channel decode; each channel is a
// led_blink_channel instance.
// Ports:
//   CLK, RST_N   : clock, asynchronous active-low reset
//   CFG_VALID    : config write request
//   CFG_READY    : config port can accept (low for one cycle after accept)
//   CFG_CH       : target channel; values >= NUM_CH are accepted and dropped
//   CFG_MODE     : 0=OFF 1=ON 2=BLINK 3=BURST
//   CFG_PERIOD   : blink period in ticks
//   CFG_HIGH     : on-time per period in ticks
//   CFG_BURST    : pulse count for BURST mode
//   LED          : registered LED drive, 1 = on
//   BURST_DONE   : sticky per-channel burst-complete flag
// Macro LED_BLINKER_BURST_EN enables BURST mode inside the channels.
// -----------------------------------------------------------------------------
module led_blinker_multi
  import led_blinker_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          CFG_VALID,
  output logic                          CFG_READY,
  input  logic [clog2_min1(NUM_CH)-1:0] CFG_CH,
  input  logic [1:0]                    CFG_MODE,
  input  logic [CNT_W-1:0]              CFG_PERIOD,
  input  logic [CNT_W-1:0]              CFG_HIGH,
  input  logic [BURST_W-1:0]            CFG_BURST,
  output logic [NUM_CH-1:0]             LED,
  output logic [NUM_CH-1:0]             BURST_DONE
);

  localparam int              CH_W     = clog2_min1(NUM_CH);
  localparam int              PRE_W    = clog2_min1(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // Prescaler: tick is high in the cycle the count sits at TICK_DIV-1. With
  // TICK_DIV=1 the count never leaves 0, so tick is permanently high.
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : (pre_q + PRE_W'(1));
  end

  // Handshake: a one-cycle ready bubble after each accept limits the port
  // to one write every two cycles.
  logic ready_q, ready_d;
  logic accept;

  always_comb begin
    accept  = CFG_VALID && ready_q;
    ready_d = !accept;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      ready_q <= ready_d;
    end
  end

  assign CFG_READY = ready_q;

  // Channel decode: an out-of-range CFG_CH simply matches no instance.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_sel;
    assign wr_sel = accept && (CFG_CH == CH_W'(gi));

    led_blink_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (CLK),
      .rst_n      (RST_N),
      .tick       (tick),
      .wr_en      (wr_sel),
      .wr_mode    (led_mode_t'(CFG_MODE)),
      .wr_period  (CFG_PERIOD),
      .wr_high    (CFG_HIGH),
      .wr_burst   (CFG_BURST),
      .led        (LED[gi]),
      .burst_done (BURST_DONE[gi])
    );
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// -----------------------------------------------------------------------------
// tb_led_blinker_multi
// Scoreboard bench: the driver pushes the expected LED / BURST_DONE /
// CFG_READY for every upcoming cycle, computed from an arithmetic channel
// model (ticks elapsed since the write, period, high time, burst count); a
// separate monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_led_blinker_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int TD     = 2;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic              CFG_VALID = 1'b0;
  logic              CFG_READY;
  logic [1:0]        CFG_CH = '0;
  logic [1:0]        CFG_MODE = '0;
  logic [CNT_W-1:0]  CFG_PERIOD = '0;
  logic [CNT_W-1:0]  CFG_HIGH = '0;
  logic [7:0]        CFG_BURST = '0;
  logic [NUM_CH-1:0] LED;
  logic [NUM_CH-1:0] BURST_DONE;

  always #5 CLK = ~CLK;

  led_blinker_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .TICK_DIV (TD)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CFG_VALID  (CFG_VALID),
    .CFG_READY  (CFG_READY),
    .CFG_CH     (CFG_CH),
    .CFG_MODE   (CFG_MODE),
    .CFG_PERIOD (CFG_PERIOD),
    .CFG_HIGH   (CFG_HIGH),
    .CFG_BURST  (CFG_BURST),
    .LED        (LED),
    .BURST_DONE (BURST_DONE)
  );

  typedef struct {
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] done;
    logic              ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model: config in effect per channel plus the cycle it took effect.
  int n_cyc;
  bit m_ready;
  int m_mode   [NUM_CH];
  int m_period [NUM_CH];
  int m_high   [NUM_CH];
  int m_burst  [NUM_CH];
  int m_apply  [NUM_CH];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c]   = 0;
      m_period[c] = 0;
      m_high[c]   = 0;
      m_burst[c]  = 0;
      m_apply[c]  = 0;
    end
    m_ready = 1'b1;
    n_cyc   = 0;
  endtask

  // State of channel c during cycle m determines its outputs in cycle m+1.
  // Ticks occur in cycles j with j%TD==TD-1, counting from reset release.
  function automatic void chan_out(input int c, input int m, output bit led, output bit done);
    int p, k, cnt, wraps;
    bit burst_on, reached;
`ifdef LED_BLINKER_BURST_EN
    burst_on = (m_mode[c] == 3);
`else
    burst_on = 1'b0;
`endif
    p       = (m_period[c] == 0) ? 1 : m_period[c];
    k       = m / TD - m_apply[c] / TD;
    cnt     = k % p;
    wraps   = k / p;
    reached = (wraps >= m_burst[c]);
    led     = 1'b0;
    done    = 1'b0;
    case (m_mode[c])
      0: led = 1'b0;
      1: led = 1'b1;
      default: begin
        led  = (burst_on && reached) ? 1'b0 : (cnt < m_high[c]);
        done = burst_on && reached;
      end
    endcase
  endfunction

  // Issue the current inputs for one clock and queue what the next cycle must show.
  task automatic step();
    exp_t e;
    bit   acc, l, d;
    acc    = CFG_VALID && m_ready;
    e.led  = '0;
    e.done = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      chan_out(c, n_cyc, l, d);
      e.led[c]  = l;
      e.done[c] = (acc && int'(CFG_CH) == c) ? 1'b0 : d;
    end
    e.ready = !acc;
    if (acc) begin
      m_mode[CFG_CH]   = int'(CFG_MODE);
      m_period[CFG_CH] = int'(CFG_PERIOD);
      m_high[CFG_CH]   = int'(CFG_HIGH);
      m_burst[CFG_CH]  = int'(CFG_BURST);
      m_apply[CFG_CH]  = n_cyc + 1;
      $display("write cyc %0d ch %0d mode %0d period %0d high %0d burst %0d",
               n_cyc, CFG_CH, CFG_MODE, CFG_PERIOD, CFG_HIGH, CFG_BURST);
    end
    m_ready = !acc;
    exp_q.push_back(e);
    last_exp = e;
    @(posedge CLK);
    #1;
    n_cyc++;
  endtask

  task automatic idle(input int n);
    CFG_VALID = 1'b0;
    repeat (n) step();
  endtask

  task automatic cfg_write(input int ch, input int mode, input int p, input int h, input int n);
    bit taken = 1'b0;
    CFG_VALID  = 1'b1;
    CFG_CH     = 2'(ch);
    CFG_MODE   = 2'(mode);
    CFG_PERIOD = CNT_W'(p);
    CFG_HIGH   = CNT_W'(h);
    CFG_BURST  = 8'(n);
    for (int i = 0; i < 4 && !taken; i++) begin
      taken = m_ready;
      step();
    end
    CFG_VALID = 1'b0;
  endtask

  // Assert reset away from a clock edge, check outputs clear at once and
  // after the hold time, then release just after a rising edge.
  task automatic do_reset(input int hold);
    mon_en    = 1'b0;
    exp_q.delete();
    CFG_VALID = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_now_led",   int'(LED), 0);
    chk("rst_now_done",  int'(BURST_DONE), 0);
    chk("rst_now_ready", int'(CFG_READY), 1);
    repeat (hold) @(posedge CLK);
    #1;
    chk("rst_hold_led",   int'(LED), 0);
    chk("rst_hold_done",  int'(BURST_DONE), 0);
    chk("rst_hold_ready", int'(CFG_READY), 1);
    RST_N = 1'b1;
    model_reset();
    exp_q.push_back('{led: '0, done: '0, ready: 1'b1});
    mon_en = 1'b1;
  endtask

  // Monitor: every falling edge the DUT presents one output sample.
  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("led",        int'(LED),        int'(mon_e.led));
          chk("burst_done", int'(BURST_DONE), int'(mon_e.done));
          chk("cfg_ready",  int'(CFG_READY),  int'(mon_e.ready));
        end
      end
    end
  end

  initial begin
    int pulses;
    bit prev;
    int hold;

    model_reset();
    do_reset(5);

    // Basic blink and the period/high boundary cases.
    cfg_write(0, 2, 4, 2, 0);
    idle(20);
    cfg_write(1, 2, 4, 0, 0);
    cfg_write(2, 2, 4, 9, 0);
    cfg_write(3, 2, 0, 1, 0);
    idle(16);
    chk("ch2_high_ge_period", int'(LED[2]), 1);
    chk("ch3_period_zero",    int'(LED[3]), 1);
    chk("ch1_high_zero",      int'(LED[1]), 0);

    // Back-to-back requests: only every other one is taken.
    CFG_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      CFG_CH     = 2'(i % 4);
      CFG_MODE   = 2'd2;
      CFG_PERIOD = CNT_W'(3 + i);
      CFG_HIGH   = CNT_W'(i);
      step();
    end
    idle(10);

    // Burst of three pulses on ch0, counted directly on the pin.
    cfg_write(0, 3, 4, 1, 3);
    pulses = 0;
    prev   = LED[0];
    for (int i = 0; i < 40; i++) begin
      step();
      if (LED[0] && !prev) pulses++;
      prev = LED[0];
    end
`ifdef LED_BLINKER_BURST_EN
    chk("burst_pulse_count", pulses, 3);
    chk("burst_done_set",    int'(BURST_DONE[0]), 1);
    chk("burst_led_idle",    int'(LED[0]), 0);
`else
    chk("burst_done_tied",   int'(BURST_DONE[0]), 0);
`endif

    // Rewrite clears the done flag; then turn OFF while the LED is lit.
    cfg_write(0, 2, 4, 2, 0);
    idle(3);
    chk("rewrite_done_clear", int'(BURST_DONE[0]), 0);
    hold = 0;
    while (!last_exp.led[0] && hold < 20) begin
      step();
      hold++;
    end
    chk("found_high_phase", int'(last_exp.led[0]), 1);
    cfg_write(0, 0, 4, 2, 0);
    step();
    chk("off_two_clk_after_accept", int'(LED[0]), 0);
    idle(4);

    // Burst with zero pulses completes on apply.
    cfg_write(1, 3, 5, 2, 0);
    idle(5);

    // Reset in the middle of a blink high phase.
    cfg_write(0, 2, 4, 2, 0);
    hold = 0;
    while (!last_exp.led[0] && hold < 20) begin
      step();
      hold++;
    end
    do_reset(3);
    idle(4);

    // Randomised traffic.
    for (int t = 0; t < 150; t++) begin
      CFG_VALID  = 1'b1;
      CFG_CH     = 2'($urandom_range(0, NUM_CH - 1));
      CFG_MODE   = 2'($urandom_range(0, 3));
      CFG_PERIOD = CNT_W'($urandom_range(0, 12));
      CFG_HIGH   = CNT_W'($urandom_range(0, 14));
      CFG_BURST  = 8'($urandom_range(0, 4));
      repeat ($urandom_range(1, 3)) step();
      idle($urandom_range(0, 30));
    end

    CFG_VALID = 1'b0;
    @(negedge CLK);
    #1;
    mon_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
